// File: rtl/seg_display_pkg.sv
// Shared constants for the 8-digit seven-segment display: digit count,
// blank pattern, hex segment table and the leading-zero test.
package seg_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  typedef logic [2:0] digit_idx_t;

  // Active-low gfedcba patterns, entry 15 first so HEX_SEG[n] decodes nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // A digit is a leading zero when it and every higher nibble of its group are zero.
  function automatic logic is_leading_zero(input logic [15:0] group, input logic [1:0] pos);
    logic [15:0] upper;
    upper = group >> {pos, 2'b00};
    return (pos != 2'd0) && (upper == 16'h0000);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver with frame-synchronous value update
// and optional per-group leading-zero blanking.
module seg7_scan_driver
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ValueHi,
  input  logic [15:0] ValueLo,
  input  logic        Load,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        FrameDone
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] presc_q, presc_d;
  digit_idx_t    digit_q, digit_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   disp_q, disp_d;
  logic [6:0]    out7_q, out7_d;
  logic [7:0]    en_q, en_d;
  logic          done_q, done_d;

  logic          tick;
  logic          frame_end;
  logic [15:0]   group;
  logic [15:0]   group_shift;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic          blank;

  assign tick        = (presc_q == CW'(REFRESH_DIV - 1));
  assign frame_end   = tick && (digit_q == digit_idx_t'(NUM_DIGITS - 1));
  assign group       = digit_q[2] ? disp_q[31:16] : disp_q[15:0];
  assign group_shift = group >> {digit_q[1:0], 2'b00};
  assign nibble      = group_shift[3:0];
  assign blank       = BLANK_LEADING && is_leading_zero(group, digit_q[1:0]);

  hex_to_seg7 u_dec (
    .nibble_i (nibble),
    .seg_o    (seg)
  );

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    digit_d    = tick ? digit_q + 1'b1 : digit_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    // A load landing on the boundary bypasses pending so it is shown this frame.
    if (frame_end) begin
      if (Load) begin
        disp_d = {ValueHi, ValueLo};
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (Load) begin
      pend_d     = {ValueHi, ValueLo};
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    out7_d = blank ? SEG_BLANK : seg;
    en_d   = blank ? '1 : ~(8'b1 << digit_q);
    done_d = frame_end;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc_q    <= '0;
      digit_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      out7_q     <= SEG_BLANK;
      en_q       <= '1;
      done_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      out7_q     <= out7_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  assign out7      = out7_q;
  assign en_out    = en_q;
  assign FrameDone = done_q;

endmodule
